// File: rtl/lut_mult_pkg.sv
// Shared constants and the reset image generator for the LUT-based multiplier.
// The default build is a 2x2 multiplier that produces a 4-bit product.
package lut_mult_pkg;

  localparam int DEF_A_W   = 2;
  localparam int DEF_B_W   = 2;
  localparam int DEF_Z_W   = DEF_A_W + DEF_B_W;
  localparam int DEF_DEPTH = 2 ** DEF_Z_W;

  // Splits the index into its {a,b} fields and returns their product.
  function automatic int unsigned default_entry(input int unsigned idx,
                                                input int unsigned b_w = DEF_B_W);
    return (idx >> b_w) * (idx & ((32'd1 << b_w) - 32'd1));
  endfunction

endpackage

// File: rtl/cfg_shift_lut.sv
// Serial configuration chain that holds the LUT contents. It also provides a
// parallel read of one entry and is preloaded with the product table on reset.
module cfg_shift_lut
  import lut_mult_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               shift_in,
  output logic               shift_out,
  input  logic [A_W+B_W-1:0] rd_idx,
  output logic [A_W+B_W-1:0] rd_data
);

  localparam int Z_W     = A_W + B_W;
  localparam int DEPTH   = 2 ** Z_W;
  localparam int CHAIN_W = DEPTH * Z_W;

  logic [CHAIN_W-1:0] chain_reg;
  logic [CHAIN_W-1:0] chain_next;
  logic [CHAIN_W-1:0] reset_image;
  logic [Z_W-1:0]     entry [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign reset_image[gi*Z_W +: Z_W] = Z_W'(default_entry(gi, B_W));
      assign entry[gi]                  = chain_reg[gi*Z_W +: Z_W];
    end
  endgenerate

  // New bits enter at the LSB, so the first bit loaded ends up in the top entry's MSB.
  always_comb begin
    chain_next = chain_reg;
    if (shift_en) begin
      chain_next = {chain_reg[CHAIN_W-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= reset_image;
    end else begin
      chain_reg <= chain_next;
    end
  end

  assign shift_out = chain_reg[CHAIN_W-1];
  assign rd_data   = entry[rd_idx];

endmodule

// File: rtl/lut_multiplier.sv
// Unsigned multiplier built from a reconfigurable product table. The z output
// is registered and holds its value while the table is being shifted.
module lut_multiplier
  import lut_mult_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic               clk,
  input  logic               global_resetn,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               cfg_en,
  input  logic               cfg_head,
  output logic               cfg_tail,
  output logic [A_W+B_W-1:0] z
);

  localparam int Z_W = A_W + B_W;

  logic [Z_W-1:0] idx;
  logic [Z_W-1:0] lut_data;
  logic [Z_W-1:0] z_reg;

  assign idx = {a, b};

  cfg_shift_lut #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_lut (
    .clk      (clk),
    .rst_n    (global_resetn),
    .shift_en (cfg_en),
    .shift_in (cfg_head),
    .shift_out(cfg_tail),
    .rd_idx   (idx),
    .rd_data  (lut_data)
  );

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      z_reg <= '0;
    end else if (!cfg_en) begin
      z_reg <= lut_data;
    end
  end

  assign z = z_reg;

endmodule

// File: tb/tb_lut_multiplier.sv
// Directed self-checking bench for the LUT multiplier. Inputs are driven and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_lut_multiplier;

  logic       clk = 1'b0;
  logic       global_resetn;
  logic [1:0] a;
  logic [1:0] b;
  logic       cfg_en;
  logic       cfg_head;
  logic       cfg_tail;
  logic [3:0] z;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  lut_multiplier dut (
    .clk          (clk),
    .global_resetn(global_resetn),
    .a            (a),
    .b            (b),
    .cfg_en       (cfg_en),
    .cfg_head     (cfg_head),
    .cfg_tail     (cfg_tail),
    .z            (z)
  );

  function automatic logic [3:0] mul(input logic [1:0] x, input logic [1:0] y);
    return {2'b00, x} * {2'b00, y};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] ev;
    logic [3:0] inv;

    // Reset state
    global_resetn = 1'b0;
    a = 2'd0; b = 2'd0; cfg_en = 1'b0; cfg_head = 1'b0;
    tick();
    check("reset_z", z, 4'h0);
    check("reset_tail", {3'b000, cfg_tail}, 4'h1);
    global_resetn = 1'b1;

    // Full product sweep, one operand pair per cycle
    for (int i = 0; i < 16; i++) begin
      ev = 4'(i);
      a = ev[3:2]; b = ev[1:0];
      tick();
      check($sformatf("prod_%0dx%0d", a, b), z, mul(ev[3:2], ev[1:0]));
    end

    // Read back entry 15 (9) MSB-first with zeros shifted in
    cfg_en = 1'b1; cfg_head = 1'b0;
    check("tail_b3", {3'b000, cfg_tail}, 4'h1); tick();
    check("tail_b2", {3'b000, cfg_tail}, 4'h0); tick();
    check("tail_b1", {3'b000, cfg_tail}, 4'h0); tick();
    check("tail_b0", {3'b000, cfg_tail}, 4'h1); tick();
    check("z_held_cfg", z, 4'h9);

    // Partial load: four shifts move every entry up by one, entry 0 becomes 0
    cfg_en = 1'b0; a = 2'd3; b = 2'd3;
    tick();
    check("partial_3x3", z, 4'h6);
    a = 2'd2; b = 2'd0;
    tick();
    check("partial_2x0", z, 4'h3);
    a = 2'd0; b = 2'd0;
    tick();
    check("partial_0x0", z, 4'h0);

    // Restore the product table
    global_resetn = 1'b0;
    tick();
    global_resetn = 1'b1;
    a = 2'd1; b = 2'd3;
    tick();
    check("restore_1x3", z, 4'h3);
    a = 2'd0; b = 2'd0;
    tick();

    // Load inverted products, top entry MSB first
    cfg_en = 1'b1;
    for (int e = 15; e >= 0; e--) begin
      for (int k = 3; k >= 0; k--) begin
        ev = 4'(e);
        inv = ~mul(ev[3:2], ev[1:0]);
        cfg_head = inv[k];
        tick();
      end
    end
    check("z_held_load", z, 4'h0);
    check("tail_after_load", {3'b000, cfg_tail}, 4'h0);
    cfg_en = 1'b0; a = 2'd3; b = 2'd3;
    tick();
    check("inv_3x3", z, 4'h6);
    a = 2'd0; b = 2'd0;
    tick();
    check("inv_0x0", z, 4'hF);
    a = 2'd1; b = 2'd2;
    tick();
    check("inv_1x2", z, 4'hD);
    a = 2'd0; b = 2'd0;
    tick();

    // Full rotation leaves contents unchanged and z frozen
    cfg_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cfg_head = cfg_tail;
      tick();
      check($sformatf("rot_hold_%0d", i), z, 4'hF);
    end
    cfg_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ev = 4'(i);
      a = ev[3:2]; b = ev[1:0];
      tick();
      check($sformatf("rot_%0dx%0d", a, b), z, ~mul(ev[3:2], ev[1:0]));
    end

    // Reset in the middle of a configuration load
    cfg_en = 1'b1; cfg_head = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("z_before_rst", z, 4'h6);
    global_resetn = 1'b0;
    #0.2;
    check("async_rst_z", z, 4'h0);
    tick();
    check("rst_hold_z", z, 4'h0);
    check("rst_tail", {3'b000, cfg_tail}, 4'h1);
    global_resetn = 1'b1; cfg_en = 1'b0; a = 2'd2; b = 2'd2;
    tick();
    check("post_rst_2x2", z, 4'h4);
    a = 2'd3; b = 2'd3;
    tick();
    check("post_rst_3x3", z, 4'h9);
    a = 2'd3; b = 2'd1;
    tick();
    check("post_rst_3x1", z, 4'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
